// File: rtl/fdma_pkg.sv
// Shared definitions for the FDMA package-port responder: beat geometry,
// FSM state encoding and address-to-word conversion.
package fdma_pkg;
  localparam int unsigned BEAT_W     = 128;
  localparam int unsigned BEAT_SHIFT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_WAIT,
    ST_RD_BURST
  } state_t;

  typedef enum logic {
    DIR_WR,
    DIR_RD
  } dir_t;

  function automatic logic [31:0] beat_index(input logic [31:0] addr);
    return addr >> BEAT_SHIFT;
  endfunction
endpackage

// File: rtl/fdma_bram_sp.sv
// Single-port beat RAM, registered read, write-first on a simultaneous write.
module fdma_bram_sp
  import fdma_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BEAT_W-1:0] din,
  output logic [BEAT_W-1:0] dout
);
  logic [BEAT_W-1:0] mem_q [0:(1<<AW)-1];
  logic [BEAT_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
      dout_q      <= din;
    end else begin
      dout_q      <= mem_q[addr];
    end
  end

  assign dout = dout_q;
endmodule

// File: rtl/fdma_pkg_responder.sv
// Memory-backed responder for the FDMA package port: one pending slot per
// direction, alternating service, optional periodic stall cycles.
module fdma_pkg_responder
  import fdma_pkg::*;
#(
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned STALL_EVERY = 0
) (
  input  logic              ui_clk,
  input  logic              ui_rst_n,
  input  logic              pkg_wr_areq,
  input  logic [31:0]       pkg_wr_addr,
  input  logic [31:0]       pkg_wr_size,
  output logic              pkg_wr_en,
  input  logic [BEAT_W-1:0] pkg_wr_data,
  output logic              pkg_wr_last,
  input  logic              pkg_rd_areq,
  input  logic [31:0]       pkg_rd_addr,
  input  logic [31:0]       pkg_rd_size,
  output logic              pkg_rd_en,
  output logic [BEAT_W-1:0] pkg_rd_data,
  output logic              pkg_rd_last,
  output logic              busy,
  output logic              req_ovf
);
  localparam logic [2:0]        WAIT_INIT = 3'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [MEM_AW-1:0] IDX_ONE   = MEM_AW'(1);

  state_t            state_q, state_d;
  dir_t              last_dir_q, last_dir_d;
  logic              wr_vld_q, wr_vld_d, rd_vld_q, rd_vld_d;
  logic [MEM_AW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [31:0]       wr_size_q, wr_size_d, rd_size_q, rd_size_d;
  logic [31:0]       cnt_q, cnt_d, gc_q, gc_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [2:0]        wait_q, wait_d;
  logic              wr_en_q, wr_en_d, wr_last_q, wr_last_d;
  logic              rd_en_q, rd_en_d, rd_last_q, rd_last_d;
  logic              ovf_q, ovf_d;

  logic [31:0]       wr_word, rd_word;
  logic              wr_take, rd_take, wr_acc, rd_acc, beat_issue, rd_issue;
  logic [MEM_AW-1:0] rd_issue_idx, ram_addr;
  logic [BEAT_W-1:0] ram_dout;
  logic              unused_word_bits;

  always_comb begin
    wr_word      = beat_index(pkg_wr_addr);
    rd_word      = beat_index(pkg_rd_addr);
    state_d      = state_q;
    last_dir_d   = last_dir_q;
    wr_vld_d     = wr_vld_q;
    rd_vld_d     = rd_vld_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    wr_size_d    = wr_size_q;
    rd_size_d    = rd_size_q;
    cnt_d        = cnt_q;
    gc_d         = gc_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    wr_en_d      = 1'b0;
    wr_last_d    = 1'b0;
    rd_en_d      = 1'b0;
    rd_last_d    = 1'b0;
    wr_take      = 1'b0;
    rd_take      = 1'b0;
    beat_issue   = 1'b0;
    rd_issue     = 1'b0;
    rd_issue_idx = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_vld_q && (!rd_vld_q || last_dir_q == DIR_RD)) begin
          wr_take    = 1'b1;
          last_dir_d = DIR_WR;
          state_d    = ST_WR_BURST;
          cnt_d      = wr_size_q;
          gc_d       = '0;
          idx_d      = wr_idx_q;
          wr_en_d    = 1'b1;
          wr_last_d  = (wr_size_q == 32'd1);
        end else if (rd_vld_q) begin
          rd_take    = 1'b1;
          last_dir_d = DIR_RD;
          cnt_d      = rd_size_q;
          gc_d       = '0;
          if (RD_LAT == 1) begin
            state_d      = ST_RD_BURST;
            rd_issue     = 1'b1;
            rd_issue_idx = rd_idx_q;
          end else begin
            state_d = ST_RD_WAIT;
            wait_d  = WAIT_INIT;
            idx_d   = rd_idx_q;
          end
        end
      end
      ST_RD_WAIT: begin
        if (wait_q == '0) begin
          state_d  = ST_RD_BURST;
          rd_issue = 1'b1;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      default: begin
        // Enables are decided one cycle ahead so reads can be issued to the RAM early.
        if (wr_en_q || rd_en_q) begin
          cnt_d = cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            state_d = ST_IDLE;
          end else if (STALL_EVERY != 0 && gc_q + 32'd1 == STALL_EVERY) begin
            gc_d = '0;
          end else begin
            gc_d       = gc_q + 32'd1;
            beat_issue = 1'b1;
          end
        end else begin
          beat_issue = 1'b1;
        end
        if (wr_en_q) idx_d = idx_q + IDX_ONE;
      end
    endcase

    if (beat_issue && state_q == ST_WR_BURST) begin
      wr_en_d   = 1'b1;
      wr_last_d = (cnt_d == 32'd1);
    end
    if (beat_issue && state_q == ST_RD_BURST) rd_issue = 1'b1;
    if (rd_issue) begin
      rd_en_d   = 1'b1;
      rd_last_d = (cnt_d == 32'd1);
      idx_d     = rd_issue_idx + IDX_ONE;
    end

    // A slot being dispatched this cycle can take a new request at the same edge.
    wr_acc = pkg_wr_areq && (pkg_wr_size != '0) && (!wr_vld_q || wr_take);
    rd_acc = pkg_rd_areq && (pkg_rd_size != '0) && (!rd_vld_q || rd_take);
    if (wr_take) wr_vld_d = 1'b0;
    if (rd_take) rd_vld_d = 1'b0;
    if (wr_acc) begin
      wr_vld_d  = 1'b1;
      wr_idx_d  = wr_word[MEM_AW-1:0];
      wr_size_d = pkg_wr_size;
    end
    if (rd_acc) begin
      rd_vld_d  = 1'b1;
      rd_idx_d  = rd_word[MEM_AW-1:0];
      rd_size_d = pkg_rd_size;
    end
    ovf_d = ovf_q | (pkg_wr_areq & ~wr_acc) | (pkg_rd_areq & ~rd_acc);
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_RD;
      wr_vld_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      wr_size_q  <= '0;
      rd_size_q  <= '0;
      cnt_q      <= '0;
      gc_q       <= '0;
      idx_q      <= '0;
      wait_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_last_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_last_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      wr_vld_q   <= wr_vld_d;
      rd_vld_q   <= rd_vld_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      wr_size_q  <= wr_size_d;
      rd_size_q  <= rd_size_d;
      cnt_q      <= cnt_d;
      gc_q       <= gc_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      wr_en_q    <= wr_en_d;
      wr_last_q  <= wr_last_d;
      rd_en_q    <= rd_en_d;
      rd_last_q  <= rd_last_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ram_addr = wr_en_q ? idx_q : rd_issue_idx;

  fdma_bram_sp #(.AW(MEM_AW)) u_bram (
    .clk  (ui_clk),
    .we   (wr_en_q),
    .addr (ram_addr),
    .din  (pkg_wr_data),
    .dout (ram_dout)
  );

  assign unused_word_bits = ^{wr_word, rd_word};

  assign pkg_wr_en   = wr_en_q;
  assign pkg_wr_last = wr_last_q;
  assign pkg_rd_en   = rd_en_q;
  assign pkg_rd_last = rd_last_q;
  assign pkg_rd_data = rd_en_q ? ram_dout : '0;
  assign busy        = (state_q != ST_IDLE);
  assign req_ovf     = ovf_q;
endmodule
